bayer_bin2x2_rgb: RTL

- Sits between the TRDB-D5M sensor capture stage and the frame transfer bus that feeds the VGA driver.
- Takes the raw 12-bit Bayer stream (G1 R / B G2 pattern) with line/frame valid qualifiers.
- Applies 2x2 binning and emits one 24-bit RGB888 pixel per Bayer quad, giving half resolution in each axis.
- Has a one-line buffer, an output valid/ready register, and frame geometry status.

---
 rtl/bayer_bin2x2_rgb.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/bayer_bin2x2_rgb.sv
// Bayer 2x2 binning stage: raw 12-bit Bayer (G1 R / B G2) in, RGB888 out.
// One output pixel per Bayer quad (half resolution in each axis).
//
// Ports:
//   piul1Clock, piul1Reset        clock, synchronous active-high reset
//   piul1PixelValid/piul12PixelData  raw sample strobe and value
//   piul1LineValid/piul1FrameValid   sensor line/frame qualifiers
//   piul1Ready                    downstream accepts the output pixel
//   poul1Valid/poul24Pixel        output pixel {R,G,B}, held until Ready
//   poul1StartOfFrame             marks the first pixel of a frame
//   poul1EndOfLine                pulse after an odd input row ends
//   poul1Overflow/poul1LineTooLong sticky error flags
//   poulOutWidth/poulOutHeight    geometry of the last completed frame
module bayer_bin2x2_rgb #(
  parameter int MAX_WIDTH = 2592,
  parameter int COUNT_W   = 12
) (
  input  logic               piul1Clock,
  input  logic               piul1Reset,
  input  logic               piul1PixelValid,
  input  logic [11:0]        piul12PixelData,
  input  logic               piul1LineValid,
  input  logic               piul1FrameValid,
  input  logic               piul1Ready,
  output logic               poul1Valid,
  output logic [23:0]        poul24Pixel,
  output logic               poul1StartOfFrame,
  output logic               poul1EndOfLine,
  output logic               poul1Overflow,
  output logic               poul1LineTooLong,
  output logic [COUNT_W-1:0] poulOutWidth,
  output logic [COUNT_W-1:0] poulOutHeight
);

  localparam int DEPTH = MAX_WIDTH / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {WAIT_IDLE, WAIT_FRAME, IN_FRAME} state_t;

  // Green is the truncated mean of the two green sites (13-bit sum, top 8 bits).
  function automatic logic [7:0] greenAvg(input logic [11:0] g1, input logic [11:0] g2);
    logic [12:0] sum;
    sum = {1'b0, g1} + {1'b0, g2};
    return sum[12:5];
  endfunction

  function automatic logic [7:0] trunc8(input logic [11:0] s);
    return s[11:4];
  endfunction

  state_t             state, stateNext;
  logic               fvPrev, lvPrev;
  logic               fvRise, fvFall, lvRise, lvFall;
  logic               inFrame, accept, inRange, colOdd, oddEnd;
  logic [COUNT_W-1:0] colCnt, colIdx;
  logic               rowOdd, firstFlag;
  logic [COUNT_W-1:0] oddRowCnt, lineOutCnt, lastOddWidth;
  logic [AW-1:0]      bufAddr;
  logic               wrEn, rdEn;
  logic [23:0]        lineBuf [DEPTH];

  // p0: accepted sample, even-column hold and line-buffer read
  logic [11:0]        prevEven_p0;
  logic [23:0]        bufRd_p0;
  logic               vld_p0;
  logic [23:0]        pixel_p0;

  // p1: output register
  logic               vld_p1, sof_p1;
  logic [23:0]        pixel_p1;

  assign fvRise  = piul1FrameValid & ~fvPrev;
  assign fvFall  = ~piul1FrameValid & fvPrev;
  assign lvRise  = piul1LineValid & ~lvPrev;
  assign lvFall  = ~piul1LineValid & lvPrev;
  assign inFrame = (state == IN_FRAME);
  assign accept  = inFrame & piul1PixelValid & piul1LineValid & piul1FrameValid;

  // The first pixel of a line can arrive together with the LineValid rise,
  // so the column index is taken as zero on that cycle.
  assign colIdx  = lvRise ? '0 : colCnt;
  assign inRange = int'(colIdx) < MAX_WIDTH;
  assign colOdd  = colIdx[0];
  assign bufAddr = AW'(colIdx >> 1);
  assign wrEn    = accept & inRange & ~rowOdd & colOdd;
  assign rdEn    = accept & inRange & rowOdd & ~colOdd & ((int'(colIdx) >> 1) < DEPTH);
  assign vld_p0  = accept & inRange & rowOdd & colOdd;
  assign oddEnd  = inFrame & lvFall & rowOdd;

  // Buffer entry is {G1, R}; prevEven holds B on odd rows, current sample is G2.
  assign pixel_p0 = {trunc8(bufRd_p0[11:0]), greenAvg(bufRd_p0[23:12], piul12PixelData),
                     trunc8(prevEven_p0)};

  always_comb begin
    stateNext = state;
    case (state)
      WAIT_IDLE:  if (!piul1FrameValid) stateNext = WAIT_FRAME;
      WAIT_FRAME: if (fvRise) stateNext = IN_FRAME;
      IN_FRAME:   if (fvFall) stateNext = WAIT_FRAME;
      default:    stateNext = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state        <= WAIT_IDLE;
      fvPrev       <= 1'b0;
      lvPrev       <= 1'b0;
      colCnt       <= '0;
      rowOdd       <= 1'b0;
      firstFlag    <= 1'b0;
      oddRowCnt    <= '0;
      lineOutCnt   <= '0;
      lastOddWidth <= '0;
      poulOutWidth <= '0;
      poulOutHeight <= '0;
      poul1EndOfLine <= 1'b0;
      poul1LineTooLong <= 1'b0;
    end else begin
      state          <= stateNext;
      fvPrev         <= piul1FrameValid;
      lvPrev         <= piul1LineValid;
      poul1EndOfLine <= oddEnd;

      if (accept) colCnt <= (colIdx == '1) ? colIdx : colIdx + 1'b1;
      else if (lvRise) colCnt <= '0;

      if (accept && !inRange) poul1LineTooLong <= 1'b1;

      if (lvRise) lineOutCnt <= '0;
      else if (vld_p0) lineOutCnt <= lineOutCnt + 1'b1;

      if (state == WAIT_FRAME && fvRise) begin
        rowOdd    <= 1'b0;
        firstFlag <= 1'b1;
        oddRowCnt <= '0;
      end else begin
        if (inFrame && lvFall) rowOdd <= ~rowOdd;
        if (oddEnd) begin
          oddRowCnt    <= oddRowCnt + 1'b1;
          lastOddWidth <= lineOutCnt;
        end
        if (vld_p0) firstFlag <= 1'b0;
      end

      // A row ending on the same cycle as the frame still counts.
      if (inFrame && fvFall) begin
        poulOutHeight <= oddRowCnt + COUNT_W'(oddEnd);
        poulOutWidth  <= oddEnd ? lineOutCnt : lastOddWidth;
      end
    end
  end

  always_ff @(posedge piul1Clock) begin
    if (accept && inRange && !colOdd) prevEven_p0 <= piul12PixelData;
    if (wrEn) lineBuf[bufAddr] <= {prevEven_p0, piul12PixelData};
    if (rdEn) bufRd_p0 <= lineBuf[bufAddr];
  end

  // p0 -> p1: load when empty or being drained, otherwise drop and flag
  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      vld_p1        <= 1'b0;
      sof_p1        <= 1'b0;
      pixel_p1      <= '0;
      poul1Overflow <= 1'b0;
    end else if (vld_p0) begin
      if (!vld_p1 || piul1Ready) begin
        vld_p1   <= 1'b1;
        sof_p1   <= firstFlag;
        pixel_p1 <= pixel_p0;
      end else begin
        poul1Overflow <= 1'b1;
      end
    end else if (vld_p1 && piul1Ready) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
    end
  end

  assign poul1Valid        = vld_p1;
  assign poul24Pixel       = pixel_p1;
  assign poul1StartOfFrame = sof_p1;

endmodule
